// File: rtl/uart_pkg.sv
// Shared types and constants for the UART snapshot transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] UART_HDR = 8'hA5;

  // Rounded clock-cycles-per-bit for a given clock and baud rate.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with baud timing; a new byte can be loaded in IDLE or
// on the last cycle of a stop bit, giving gapless back-to-back bytes.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       ready_c,
  output logic       tx
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shreg, shreg_next;
  logic          tx_next;
  logic          bit_end;

  // State, counters, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shreg   <= shreg_next;
      tx      <= tx_next;
    end
  end

  // Next-state, baud/bit counting and line level derived from the next state.
  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shreg_next = shreg;
    ready_c    = 1'b0;
    bit_end    = (baud == '0);

    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (load) begin
          state_next = START;
          baud_next  = BAUD_TOP;
          shreg_next = tx_byte;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = BAUD_TOP;
          bit_next   = '0;
        end else begin
          baud_next = baud - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = BAUD_TOP;
          shreg_next = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          ready_c = 1'b1;
          if (load) begin
            state_next = START;
            baud_next  = BAUD_TOP;
            shreg_next = tx_byte;
          end else begin
            state_next = IDLE;
            baud_next  = '0;
          end
        end else begin
          baud_next = baud - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_snapshot_tx.sv
// Sends a header, the snapshot bytes (MSB first) and their XOR checksum as
// one gapless 8N1 burst per accepted request.
module uart_snapshot_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(100_000_000, 115_200),
  parameter int unsigned NBYTES       = 8
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   snapshot,
  output logic                  tx_pin_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned SW = 8 * NBYTES;
  localparam int unsigned IW = $clog2(NBYTES + 2);
  localparam logic [IW-1:0] CSUM_IDX = IW'(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES + 1);

  logic [SW-1:0] shadow;
  logic [IW-1:0] byte_idx;
  logic [7:0]    checksum;
  logic          ready_c;
  logic          load_c;
  logic [7:0]    tx_byte_c;
  logic [7:0]    payload_c;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk     (CLK100MHZ),
    .reset   (reset),
    .load    (load_c),
    .tx_byte (tx_byte_c),
    .ready_c (ready_c),
    .tx      (tx_pin_out)
  );

  // Chooses the byte handed to the serialiser: header on acceptance, then
  // payload from the top of the shifting shadow, then the checksum.
  always_comb begin
    load_c    = 1'b0;
    tx_byte_c = UART_HDR;
    payload_c = shadow[SW-1 -: 8];
    if (!busy) begin
      load_c = start;
    end else if (ready_c && (byte_idx != LAST_IDX)) begin
      load_c    = 1'b1;
      tx_byte_c = (byte_idx == CSUM_IDX) ? checksum : payload_c;
    end
  end

  // Acceptance, byte sequencing, checksum accumulation and frame status.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_idx   <= '0;
      checksum   <= '0;
      shadow     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          shadow   <= snapshot;
          checksum <= '0;
          byte_idx <= '0;
        end
      end else if (ready_c) begin
        if (byte_idx == LAST_IDX) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
          byte_idx   <= '0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx < CSUM_IDX) begin
            checksum <= checksum ^ payload_c;
            shadow   <= shadow << 8;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_snapshot_tx.sv
// Directed + randomized bench for uart_snapshot_tx with a line-level model.
module tb_uart_snapshot_tx;

  localparam int unsigned CPB       = 4;
  localparam int unsigned NB        = 8;
  localparam int unsigned NFB       = NB + 2;
  localparam int unsigned BYTE_CYC  = 10 * CPB;
  localparam int unsigned FRAME_CYC = NFB * BYTE_CYC;

  logic        CLK100MHZ = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] snapshot;
  logic        tx_pin_out;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  logic       cap[FRAME_CYC];
  logic [7:0] exp_b[NFB];
  int         bad_busy;
  int         early_fd;

  always #5 CLK100MHZ = ~CLK100MHZ;

  uart_snapshot_tx #(
    .CLKS_PER_BIT(CPB),
    .NBYTES      (NB)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .start     (start),
    .snapshot  (snapshot),
    .tx_pin_out(tx_pin_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame bytes: header, snapshot MSB first, XOR of payload.
  task automatic build_exp(input logic [63:0] s);
    logic [63:0] t;
    logic [7:0]  x;
    x = 8'h00;
    exp_b[0] = 8'hA5;
    for (int k = 0; k < NB; k++) begin
      t = s >> (8 * (NB - 1 - k));
      exp_b[k+1] = t[7:0];
      x = x ^ t[7:0];
    end
    exp_b[NFB-1] = x;
  endtask

  // Ideal line level at frame cycle i.
  function automatic logic exp_line(input int i);
    int b;
    int slot;
    logic [7:0] v;
    b    = i / BYTE_CYC;
    slot = (i % BYTE_CYC) / CPB;
    v    = exp_b[b];
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return v[slot-1];
  endfunction

  task automatic start_frame(input logic [63:0] s);
    snapshot = s;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // Records FRAME_CYC line samples starting at the first busy cycle.
  task automatic capture(input int poke_at, input logic [63:0] poke_snap);
    bad_busy = 0;
    early_fd = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      cap[i] = tx_pin_out;
      if (busy !== 1'b1) bad_busy++;
      if (frame_done !== 1'b0) early_fd++;
      if (i == poke_at) begin
        start    = 1'b1;
        snapshot = poke_snap;
      end else if (i == poke_at + 1) begin
        start = 1'b0;
      end
      step();
    end
  endtask

  task automatic check_end(input string tag);
    check({tag, " frame_done"}, 64'(frame_done), 64'd1);
    check({tag, " busy_end"}, 64'(busy), 64'd0);
    check({tag, " tx_end"}, 64'(tx_pin_out), 64'd1);
  endtask

  task automatic check_frame(input string tag);
    int wave_err;
    logic [7:0] d;
    wave_err = 0;
    for (int i = 0; i < FRAME_CYC; i++)
      if (cap[i] !== exp_line(i)) wave_err++;
    check({tag, " waveform_err"}, 64'(wave_err), 64'd0);
    check({tag, " busy_gaps"}, 64'(bad_busy), 64'd0);
    check({tag, " early_done"}, 64'(early_fd), 64'd0);
    for (int b = 0; b < NFB; b++) begin
      for (int k = 0; k < 8; k++)
        d[k] = cap[b * BYTE_CYC + CPB * (1 + k) + CPB / 2];
      check($sformatf("%s byte%0d", tag, b), 64'(d), 64'(exp_b[b]));
    end
  endtask

  task automatic watch_idle(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (busy !== 1'b0 || tx_pin_out !== 1'b1 || frame_done !== 1'b0) bad++;
      step();
    end
    check({tag, " idle_anomalies"}, 64'(bad), 64'd0);
  endtask

  task automatic full_frame(input string tag, input logic [63:0] s);
    build_exp(s);
    start_frame(s);
    check({tag, " busy_rise"}, 64'(busy), 64'd1);
    check({tag, " first_start_bit"}, 64'(tx_pin_out), 64'd0);
    capture(-5, 64'd0);
    check_end(tag);
    check_frame(tag);
    step();
    check({tag, " done_one_cycle"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    logic [63:0] s1;
    logic [63:0] s2;

    reset    = 1'b1;
    start    = 1'b0;
    snapshot = 64'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d tx", i), 64'(tx_pin_out), 64'd1);
      check($sformatf("rst%0d busy", i), 64'(busy), 64'd0);
      check($sformatf("rst%0d done", i), 64'(frame_done), 64'd0);
    end
    reset = 1'b0;
    step();

    full_frame("known", 64'h0123_4567_89AB_CDEF);
    full_frame("csum", 64'h0000_0000_0000_00FF);
    for (int r = 0; r < 3; r++)
      full_frame($sformatf("rand%0d", r), {$urandom, $urandom});

    // Request and new snapshot while busy must not disturb the frame.
    s1 = {$urandom, $urandom};
    s2 = ~s1;
    build_exp(s1);
    start_frame(s1);
    capture(100, s2);
    check_end("ignore");
    check_frame("ignore");
    step();
    watch_idle("ignore", 60);

    // Reset during byte 4, data bit 3.
    start_frame({$urandom, $urandom});
    for (int i = 0; i < 4 * BYTE_CYC + CPB * 4 + 1; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst tx", 64'(tx_pin_out), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    watch_idle("midrst", FRAME_CYC + 50);
    full_frame("after_rst", {$urandom, $urandom});

    // Reset and start together: reset wins.
    reset    = 1'b1;
    start    = 1'b1;
    snapshot = {$urandom, $urandom};
    step();
    reset = 1'b0;
    start = 1'b0;
    check("rst_start busy", 64'(busy), 64'd0);
    check("rst_start tx", 64'(tx_pin_out), 64'd1);
    watch_idle("rst_start", 20);

    // Level start: second frame's start bit follows frame_done directly.
    s1 = {$urandom, $urandom};
    s2 = {$urandom, $urandom};
    build_exp(s1);
    snapshot = s1;
    start    = 1'b1;
    step();
    capture(-5, 64'd0);
    check_end("level1");
    check_frame("level1");
    snapshot = s2;
    build_exp(s2);
    step();
    start = 1'b0;
    check("level2 busy_rise", 64'(busy), 64'd1);
    check("level2 start_bit", 64'(tx_pin_out), 64'd0);
    capture(-5, 64'd0);
    check_end("level2");
    check_frame("level2");
    step();
    watch_idle("level_tail", 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
